// File: rtl/tlb_entry_cache.sv
// tlb_entry_cache: fully-associative leaf translation store feeding the TLB
// entry-data barrier. PTW refills write entries, lookups answer one cycle
// later with registered PPN and permission/fault flags, sfence invalidates
// either everything or a single VPN.
module tlb_entry_cache #(
  parameter int ENTRIES  = 8,
  parameter int VPN_BITS = 27,
  parameter int PPN_BITS = 21
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_req_valid,
  input  logic [VPN_BITS-1:0] io_req_vpn,
  output logic                io_resp_valid,
  output logic                io_resp_hit,
  output logic [PPN_BITS-1:0] io_resp_ppn,
  output logic                io_resp_u,
  output logic                io_resp_ae_ptw,
  output logic                io_resp_ae_final,
  output logic                io_resp_pf,
  output logic                io_resp_gf,
  output logic                io_resp_sx,
  output logic                io_resp_px,
  input  logic                io_refill_valid,
  input  logic [VPN_BITS-1:0] io_refill_vpn,
  input  logic [PPN_BITS-1:0] io_refill_ppn,
  input  logic                io_refill_u,
  input  logic                io_refill_ae_ptw,
  input  logic                io_refill_ae_final,
  input  logic                io_refill_pf,
  input  logic                io_refill_gf,
  input  logic                io_refill_sx,
  input  logic                io_refill_px,
  input  logic                io_sfence_valid,
  input  logic                io_sfence_rs1,
  input  logic [VPN_BITS-1:0] io_sfence_vpn,
  output logic                io_full
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // Flags packed as {u, ae_ptw, ae_final, pf, gf, sx, px}.
  logic [ENTRIES-1:0]  valid;
  logic [VPN_BITS-1:0] tag_q   [ENTRIES];
  logic [PPN_BITS-1:0] ppn_q   [ENTRIES];
  logic [6:0]          flags_q [ENTRIES];
  logic [IDX_W-1:0]    rr;

  logic                req_hit;
  logic [PPN_BITS-1:0] hit_ppn;
  logic [6:0]          hit_flags;
  logic                refill_hit;
  logic [IDX_W-1:0]    refill_idx;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    victim;
  logic [ENTRIES-1:0]  sfence_match;
  logic                refill_en;
  logic [6:0]          refill_flags;

  logic                resp_valid_q;
  logic                resp_hit_q;
  logic [PPN_BITS-1:0] resp_ppn_q;
  logic [6:0]          resp_flags_q;

  assign refill_en    = io_refill_valid && !io_sfence_valid;
  assign refill_flags = {io_refill_u, io_refill_ae_ptw, io_refill_ae_final,
                         io_refill_pf, io_refill_gf, io_refill_sx, io_refill_px};
  assign io_full      = &valid;

  // Associative match for lookup, refill and sfence; hit data is OR-reduced
  // since at most one entry can match a VPN.
  always_comb begin
    req_hit      = 1'b0;
    hit_ppn      = '0;
    hit_flags    = '0;
    refill_hit   = 1'b0;
    refill_idx   = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    sfence_match = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid[i] && (tag_q[i] == io_req_vpn)) begin
        req_hit   = 1'b1;
        hit_ppn   = hit_ppn | ppn_q[i];
        hit_flags = hit_flags | flags_q[i];
      end
      if (valid[i] && (tag_q[i] == io_refill_vpn)) begin
        refill_hit = 1'b1;
        refill_idx = i[IDX_W-1:0];
      end
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
      sfence_match[i] = valid[i] && (tag_q[i] == io_sfence_vpn);
    end
    if (refill_hit)
      victim = refill_idx;
    else if (free_found)
      victim = free_idx;
    else
      victim = rr;
  end

  // Valid bits and round-robin pointer; sfence takes priority over refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      rr    <= '0;
    end else if (io_sfence_valid) begin
      if (io_sfence_rs1)
        valid <= valid & ~sfence_match;
      else
        valid <= '0;
    end else if (io_refill_valid) begin
      valid[victim] <= 1'b1;
      if (!refill_hit && !free_found)
        rr <= rr + 1'b1;
    end
  end

  // Entry payload storage; contents are don't-care while invalid.
  always_ff @(posedge clock) begin
    if (!reset && refill_en) begin
      tag_q[victim]   <= io_refill_vpn;
      ppn_q[victim]   <= io_refill_ppn;
      flags_q[victim] <= refill_flags;
    end
  end

  // Registered lookup response; data forced to zero unless a valid hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_ppn_q   <= '0;
      resp_flags_q <= '0;
    end else begin
      resp_valid_q <= io_req_valid;
      resp_hit_q   <= io_req_valid && req_hit;
      resp_ppn_q   <= (io_req_valid && req_hit) ? hit_ppn : '0;
      resp_flags_q <= (io_req_valid && req_hit) ? hit_flags : '0;
    end
  end

  assign io_resp_valid    = resp_valid_q;
  assign io_resp_hit      = resp_hit_q;
  assign io_resp_ppn      = resp_ppn_q;
  assign io_resp_u        = resp_flags_q[6];
  assign io_resp_ae_ptw   = resp_flags_q[5];
  assign io_resp_ae_final = resp_flags_q[4];
  assign io_resp_pf       = resp_flags_q[3];
  assign io_resp_gf       = resp_flags_q[2];
  assign io_resp_sx       = resp_flags_q[1];
  assign io_resp_px       = resp_flags_q[0];
endmodule

// File: tb/tb_tlb_entry_cache.sv
// tb_tlb_entry_cache: directed scenarios with hand-computed responses.
module tb_tlb_entry_cache;
  localparam int VB = 27;
  localparam int PB = 21;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_req_valid;
  logic [VB-1:0] io_req_vpn;
  logic          io_resp_valid, io_resp_hit;
  logic [PB-1:0] io_resp_ppn;
  logic          io_resp_u, io_resp_ae_ptw, io_resp_ae_final, io_resp_pf;
  logic          io_resp_gf, io_resp_sx, io_resp_px;
  logic          io_refill_valid;
  logic [VB-1:0] io_refill_vpn;
  logic [PB-1:0] io_refill_ppn;
  logic [6:0]    rf_flags;
  logic          io_sfence_valid, io_sfence_rs1;
  logic [VB-1:0] io_sfence_vpn;
  logic          io_full;

  int total = 0;
  int bad   = 0;

  // {valid, hit, ppn, u, ae_ptw, ae_final, pf, gf, sx, px}
  logic [PB+8:0] resp;
  assign resp = {io_resp_valid, io_resp_hit, io_resp_ppn, io_resp_u, io_resp_ae_ptw,
                 io_resp_ae_final, io_resp_pf, io_resp_gf, io_resp_sx, io_resp_px};

  tlb_entry_cache #(.ENTRIES(8), .VPN_BITS(VB), .PPN_BITS(PB)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_vpn(io_req_vpn),
    .io_resp_valid(io_resp_valid), .io_resp_hit(io_resp_hit), .io_resp_ppn(io_resp_ppn),
    .io_resp_u(io_resp_u), .io_resp_ae_ptw(io_resp_ae_ptw), .io_resp_ae_final(io_resp_ae_final),
    .io_resp_pf(io_resp_pf), .io_resp_gf(io_resp_gf), .io_resp_sx(io_resp_sx),
    .io_resp_px(io_resp_px),
    .io_refill_valid(io_refill_valid), .io_refill_vpn(io_refill_vpn),
    .io_refill_ppn(io_refill_ppn),
    .io_refill_u(rf_flags[6]), .io_refill_ae_ptw(rf_flags[5]), .io_refill_ae_final(rf_flags[4]),
    .io_refill_pf(rf_flags[3]), .io_refill_gf(rf_flags[2]), .io_refill_sx(rf_flags[1]),
    .io_refill_px(rf_flags[0]),
    .io_sfence_valid(io_sfence_valid), .io_sfence_rs1(io_sfence_rs1),
    .io_sfence_vpn(io_sfence_vpn), .io_full(io_full)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [PB+8:0] e_hit(input logic [PB-1:0] p, input logic [6:0] f);
    return {2'b11, p, f};
  endfunction

  function automatic logic [PB+8:0] e_miss();
    return {2'b10, {(PB+7){1'b0}}};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_refill(input logic [VB-1:0] v, input logic [PB-1:0] p, input logic [6:0] f);
    io_refill_valid = 1'b1;
    io_refill_vpn   = v;
    io_refill_ppn   = p;
    rf_flags        = f;
    tick();
    io_refill_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [VB-1:0] v);
    io_req_valid = 1'b1;
    io_req_vpn   = v;
    tick();
    io_req_valid = 1'b0;
  endtask

  task automatic do_sfence(input logic rs1, input logic [VB-1:0] v);
    io_sfence_valid = 1'b1;
    io_sfence_rs1   = rs1;
    io_sfence_vpn   = v;
    tick();
    io_sfence_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (resp !== '0) begin
      $display("FAIL reset_resp got=%h exp=%h", resp, {(PB+9){1'b0}}); bad++;
    end
    total++;
    if (io_full !== 1'b0) begin
      $display("FAIL reset_full got=%b exp=0", io_full); bad++;
    end
    do_lookup(27'h1234);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL reset_lookup got=%h exp=%h", resp, e_miss()); bad++;
    end
  endtask

  task automatic test_refill_hit();
    do_reset();
    io_req_valid    = 1'b1;
    io_req_vpn      = 27'h1234;
    io_refill_valid = 1'b1;
    io_refill_vpn   = 27'h1234;
    io_refill_ppn   = 21'h0ABCD;
    rf_flags        = 7'b1000010;
    tick();
    io_refill_valid = 1'b0;
    io_req_valid    = 1'b0;
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL same_cycle_miss got=%h exp=%h", resp, e_miss()); bad++;
    end
    do_lookup(27'h1234);
    total++;
    if (resp !== e_hit(21'h0ABCD, 7'b1000010)) begin
      $display("FAIL refill_hit got=%h exp=%h", resp, e_hit(21'h0ABCD, 7'b1000010)); bad++;
    end
    tick();
    total++;
    if (resp !== '0) begin
      $display("FAIL idle_resp got=%h exp=0", resp); bad++;
    end
  endtask

  task automatic test_fill_replace();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_refill(27'h100 + 27'(i), 21'h200 + 21'(i), 7'(i));
      if (i == 6) begin
        total++;
        if (io_full !== 1'b0) begin
          $display("FAIL full_at7 got=%b exp=0", io_full); bad++;
        end
      end
    end
    total++;
    if (io_full !== 1'b1) begin
      $display("FAIL full_at8 got=%b exp=1", io_full); bad++;
    end
    do_refill(27'h900, 21'h900, 7'b0100000);
    do_lookup(27'h100);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL evict0 got=%h exp=%h", resp, e_miss()); bad++;
    end
    do_lookup(27'h900);
    total++;
    if (resp !== e_hit(21'h900, 7'b0100000)) begin
      $display("FAIL new9 got=%h exp=%h", resp, e_hit(21'h900, 7'b0100000)); bad++;
    end
    do_refill(27'h901, 21'h901, 7'b0);
    do_lookup(27'h101);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL evict1 got=%h exp=%h", resp, e_miss()); bad++;
    end
    do_lookup(27'h102);
    total++;
    if (resp !== e_hit(21'h202, 7'd2)) begin
      $display("FAIL keep2 got=%h exp=%h", resp, e_hit(21'h202, 7'd2)); bad++;
    end
  endtask

  // Continues from test_fill_replace: rr = 2, entries hold 0x900,0x901,0x102..0x107.
  task automatic test_update_existing();
    do_refill(27'h105, 21'h00055, 7'b0000001);
    total++;
    if (io_full !== 1'b1) begin
      $display("FAIL update_full got=%b exp=1", io_full); bad++;
    end
    do_lookup(27'h105);
    total++;
    if (resp !== e_hit(21'h00055, 7'b0000001)) begin
      $display("FAIL update_hit got=%h exp=%h", resp, e_hit(21'h00055, 7'b0000001)); bad++;
    end
    do_refill(27'h902, 21'h902, 7'b0);
    do_lookup(27'h102);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL rr_evict2 got=%h exp=%h", resp, e_miss()); bad++;
    end
    do_lookup(27'h103);
    total++;
    if (resp !== e_hit(21'h203, 7'd3)) begin
      $display("FAIL rr_keep3 got=%h exp=%h", resp, e_hit(21'h203, 7'd3)); bad++;
    end
  endtask

  task automatic test_back_to_back();
    io_req_valid = 1'b1;
    io_req_vpn   = 27'h104;
    tick();
    total++;
    if (resp !== e_hit(21'h204, 7'd4)) begin
      $display("FAIL b2b_0 got=%h exp=%h", resp, e_hit(21'h204, 7'd4)); bad++;
    end
    io_req_vpn = 27'h902;
    tick();
    total++;
    if (resp !== e_hit(21'h902, 7'd0)) begin
      $display("FAIL b2b_1 got=%h exp=%h", resp, e_hit(21'h902, 7'd0)); bad++;
    end
    io_req_vpn = 27'h5555;
    tick();
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL b2b_2 got=%h exp=%h", resp, e_miss()); bad++;
    end
    io_req_valid = 1'b0;
    tick();
    total++;
    if (resp !== '0) begin
      $display("FAIL b2b_idle got=%h exp=0", resp); bad++;
    end
  endtask

  task automatic test_sfence();
    do_reset();
    do_refill(27'h1234, 21'h0ABCD, 7'b1000010);
    for (int i = 1; i < 8; i++)
      do_refill(27'h300 + 27'(i), 21'h400 + 21'(i), 7'b0);
    do_sfence(1'b1, 27'h1234);
    total++;
    if (io_full !== 1'b0) begin
      $display("FAIL sf1_full got=%b exp=0", io_full); bad++;
    end
    do_lookup(27'h1234);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL sf1_target got=%h exp=%h", resp, e_miss()); bad++;
    end
    do_lookup(27'h303);
    total++;
    if (resp !== e_hit(21'h403, 7'b0)) begin
      $display("FAIL sf1_other got=%h exp=%h", resp, e_hit(21'h403, 7'b0)); bad++;
    end
    do_refill(27'h400, 21'h1400, 7'b0);
    total++;
    if (io_full !== 1'b1) begin
      $display("FAIL sf1_refull got=%b exp=1", io_full); bad++;
    end
    // rr still 0, so the next new VPN evicts entry 0 (the one just refilled)
    do_refill(27'h401, 21'h1401, 7'b0001000);
    do_lookup(27'h400);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL sf1_rr got=%h exp=%h", resp, e_miss()); bad++;
    end
    do_lookup(27'h401);
    total++;
    if (resp !== e_hit(21'h1401, 7'b0001000)) begin
      $display("FAIL sf1_new got=%h exp=%h", resp, e_hit(21'h1401, 7'b0001000)); bad++;
    end
    do_sfence(1'b0, 27'h0);
    total++;
    if (io_full !== 1'b0) begin
      $display("FAIL sf0_full got=%b exp=0", io_full); bad++;
    end
    do_lookup(27'h401);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL sf0_a got=%h exp=%h", resp, e_miss()); bad++;
    end
    do_lookup(27'h305);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL sf0_b got=%h exp=%h", resp, e_miss()); bad++;
    end
  endtask

  task automatic test_sfence_refill_collision();
    do_reset();
    io_refill_valid = 1'b1;
    io_refill_vpn   = 27'h77;
    io_refill_ppn   = 21'h77;
    rf_flags        = 7'b0;
    do_sfence(1'b1, 27'h88);
    io_refill_valid = 1'b0;
    do_lookup(27'h77);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL collide_rs1 got=%h exp=%h", resp, e_miss()); bad++;
    end
    io_refill_valid = 1'b1;
    do_sfence(1'b0, 27'h0);
    io_refill_valid = 1'b0;
    do_lookup(27'h77);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL collide_rs0 got=%h exp=%h", resp, e_miss()); bad++;
    end
  endtask

  task automatic test_reset_midflight();
    do_refill(27'h55, 21'h66, 7'b0000100);
    do_lookup(27'h55);
    total++;
    if (resp !== e_hit(21'h66, 7'b0000100)) begin
      $display("FAIL pre_reset_hit got=%h exp=%h", resp, e_hit(21'h66, 7'b0000100)); bad++;
    end
    io_req_valid = 1'b1;
    io_req_vpn   = 27'h55;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
    io_req_valid = 1'b0;
    total++;
    if (resp !== '0) begin
      $display("FAIL reset_inflight got=%h exp=0", resp); bad++;
    end
    do_lookup(27'h55);
    total++;
    if (resp !== e_miss()) begin
      $display("FAIL post_reset_miss got=%h exp=%h", resp, e_miss()); bad++;
    end
  endtask

  initial begin
    reset           = 1'b1;
    io_req_valid    = 1'b0;
    io_req_vpn      = '0;
    io_refill_valid = 1'b0;
    io_refill_vpn   = '0;
    io_refill_ppn   = '0;
    rf_flags        = '0;
    io_sfence_valid = 1'b0;
    io_sfence_rs1   = 1'b0;
    io_sfence_vpn   = '0;
    tick();
    test_reset();
    test_refill_hit();
    test_fill_replace();
    test_update_existing();
    test_back_to_back();
    test_sfence();
    test_sfence_refill_collision();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
